// File: rtl/gtwiz_drp_rmw_pkg.sv
// Shared types and helpers for the DRP read-modify-write sequencer.
// Holds the FSM state enum, error codes and flat-port field slicing.
package gtwiz_drp_rmw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_VF_RD,
        S_VF_WAIT,
        S_NEXT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;

    // Upper bound on any flattened cfg/drpdo bus width.
    localparam int FLAT_MAX = 2048;

    // Field i of width w moved to the LSBs; caller truncates to w bits.
    function automatic logic [FLAT_MAX-1:0] field(
        input logic [FLAT_MAX-1:0] flat,
        input int                  w,
        input int                  i
    );
        return flat >> (w * i);
    endfunction

endpackage

// File: rtl/gtwiz_drp_wait_timer.sv
// Saturating wait counter for one DRP access.
// Ports: clk, rst_n, clr (restart at 0), en (count), expired (count==LIMIT).
module gtwiz_drp_wait_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/gtfwizard_0_example_gtwiz_drp_rmw_seq.sv
// DRP read-modify-write sequencer: walks a port-loaded register table on
// every channel, merging keep bits from the read value, optional verify.
// Ports: freerun clk / async rstn, start/alt_mode control, cfg_* table,
// per-channel drprdy/drpdo in, one-hot drpen/drpwe + shared addr/di out,
// busy/done status and first-error code/channel/entry.
module gtfwizard_0_example_gtwiz_drp_rmw_seq
    import gtwiz_drp_rmw_pkg::*;
#(
    parameter int   NUM_REG     = 3,
    parameter int   NUM_CH      = 1,
    parameter int   ADDR_W      = 10,
    parameter int   DATA_W      = 16,
    parameter int   TIMEOUT_CYC = 1023,
    parameter logic VERIFY_EN   = 1'b0,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int  IDX_W       = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
    input  logic                      freerun_clk_in,
    input  logic                      freerun_rstn_in,
    input  logic                      start_in,
    input  logic                      alt_mode_in,
    input  logic [NUM_REG*ADDR_W-1:0] cfg_addr_in,
    input  logic [NUM_REG*DATA_W-1:0] cfg_keep_in,
    input  logic [NUM_REG*DATA_W-1:0] cfg_data_in,
    input  logic [NUM_REG*DATA_W-1:0] cfg_alt_data_in,
    input  logic [NUM_REG-1:0]        cfg_alt_en_in,
    input  logic [NUM_CH-1:0]         drprdy_in,
    input  logic [NUM_CH*DATA_W-1:0]  drpdo_in,
    output logic [NUM_CH-1:0]         drpen_out,
    output logic [NUM_CH-1:0]         drpwe_out,
    output logic [ADDR_W-1:0]         drpaddr_out,
    output logic [DATA_W-1:0]         drpdi_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [1:0]                err_code_out,
    output logic [CH_W-1:0]           err_ch_out,
    output logic [IDX_W-1:0]          err_idx_out
);

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REG - 1);

    state_t             state, state_n;
    logic               start_q;
    logic               alt_q, alt_n;
    logic [CH_W-1:0]    ch, ch_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [DATA_W-1:0]  wd_n;
    logic               busy_n, done_n;
    logic [1:0]         err_n;
    logic [CH_W-1:0]    err_ch_n;
    logic [IDX_W-1:0]   err_idx_n;
    logic               tmr_clr, expired;

    logic [FLAT_MAX-1:0] addr_flat, keep_flat, data_flat, alt_flat, do_flat;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_keep, cur_data, cur_alt, cur_do, merged;
    logic [NUM_CH-1:0]   onehot;
    logic                cur_rdy, use_alt, in_wait, start_edge;

    assign addr_flat = FLAT_MAX'(cfg_addr_in);
    assign keep_flat = FLAT_MAX'(cfg_keep_in);
    assign data_flat = FLAT_MAX'(cfg_data_in);
    assign alt_flat  = FLAT_MAX'(cfg_alt_data_in);
    assign do_flat   = FLAT_MAX'(drpdo_in);

    assign cur_addr = ADDR_W'(field(addr_flat, ADDR_W, int'(idx)));
    assign cur_keep = DATA_W'(field(keep_flat, DATA_W, int'(idx)));
    assign cur_data = DATA_W'(field(data_flat, DATA_W, int'(idx)));
    assign cur_alt  = DATA_W'(field(alt_flat, DATA_W, int'(idx)));
    assign cur_do   = DATA_W'(field(do_flat, DATA_W, int'(ch)));

    assign onehot  = NUM_CH'(1) << ch;
    // Only the active channel's ready counts; others are ignored.
    assign cur_rdy = |(drprdy_in & onehot);
    assign use_alt = alt_q & |(cfg_alt_en_in & (NUM_REG'(1) << idx));
    assign merged  = ((use_alt ? cur_alt : cur_data) & ~cur_keep)
                   | (cur_do & cur_keep);

    assign in_wait    = state inside {S_RD_WAIT, S_WR_WAIT, S_VF_WAIT};
    assign start_edge = start_in & ~start_q;

    // Outputs decode from the async-reset state, so drpen drops at once.
    assign drpen_out   = (state inside {S_RD, S_WR, S_VF_RD}) ? onehot : '0;
    assign drpwe_out   = (state == S_WR) ? onehot : '0;
    assign drpaddr_out = (state != S_IDLE) ? cur_addr : '0;

    gtwiz_drp_wait_timer #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_timer (
        .clk     (freerun_clk_in),
        .rst_n   (freerun_rstn_in),
        .clr     (tmr_clr),
        .en      (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_n   = state;
        alt_n     = alt_q;
        ch_n      = ch;
        idx_n     = idx;
        wd_n      = drpdi_out;
        busy_n    = busy_out;
        done_n    = done_out;
        err_n     = err_code_out;
        err_ch_n  = err_ch_out;
        err_idx_n = err_idx_out;
        tmr_clr   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_edge) begin
                    alt_n     = alt_mode_in;
                    done_n    = 1'b0;
                    err_n     = ERR_NONE;
                    err_ch_n  = '0;
                    err_idx_n = '0;
                    ch_n      = '0;
                    idx_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = S_RD;
                end
            end
            S_RD: begin
                tmr_clr = 1'b1;
                state_n = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cur_rdy) begin
                    wd_n    = merged;
                    state_n = S_WR;
                end
            end
            S_WR: begin
                tmr_clr = 1'b1;
                state_n = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (cur_rdy) begin
                    state_n = VERIFY_EN ? S_VF_RD : S_NEXT;
                end
            end
            S_VF_RD: begin
                tmr_clr = 1'b1;
                state_n = S_VF_WAIT;
            end
            S_VF_WAIT: begin
                if (cur_rdy) begin
                    // Mismatch is recorded but the walk carries on.
                    if (cur_do != drpdi_out && err_code_out == ERR_NONE) begin
                        err_n     = ERR_VERIFY;
                        err_ch_n  = ch;
                        err_idx_n = idx;
                    end
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    idx_n = '0;
                    if (ch == LAST_CH) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ch_n    = ch + 1'b1;
                        state_n = S_RD;
                    end
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = S_RD;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A missing drprdy aborts the whole sequence.
        if (in_wait && !cur_rdy && expired) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            if (err_code_out == ERR_NONE) begin
                err_n     = ERR_TIMEOUT;
                err_ch_n  = ch;
                err_idx_n = idx;
            end
        end
    end

    always_ff @(posedge freerun_clk_in or negedge freerun_rstn_in) begin
        if (!freerun_rstn_in) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            alt_q        <= 1'b0;
            ch           <= '0;
            idx          <= '0;
            drpdi_out    <= '0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            err_code_out <= ERR_NONE;
            err_ch_out   <= '0;
            err_idx_out  <= '0;
        end else begin
            state        <= state_n;
            start_q      <= start_in;
            alt_q        <= alt_n;
            ch           <= ch_n;
            idx          <= idx_n;
            drpdi_out    <= wd_n;
            busy_out     <= busy_n;
            done_out     <= done_n;
            err_code_out <= err_n;
            err_ch_out   <= err_ch_n;
            err_idx_out  <= err_idx_n;
        end
    end

endmodule

// File: tb/tb_gtfwizard_0_example_gtwiz_drp_rmw_seq.sv
// Bench for the DRP RMW sequencer: dut A (2 channels, short timeout,
// no verify) and dut B (1 channel, verify) against a DRP memory model.
module tb_gtfwizard_0_example_gtwiz_drp_rmw_seq;

    localparam int LAT = 2;

    typedef struct {
        int         p;
        logic [9:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        string       nm;
        bit          alt_mode;
        logic [2:0]  alt_en;
        logic [15:0] alt_d;
        logic [15:0] init;
        bit          mute1;
        logic [15:0] wd0, wd1, wd2;
        logic [1:0]  err;
        logic        ech;
        logic [1:0]  eidx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic alt_a = 1'b0, alt_b = 1'b0;
    logic [29:0] cfg_addr;
    logic [47:0] cfg_keep, cfg_data, cfg_alt;
    logic [2:0]  cfg_alt_en;

    logic [1:0]  drprdy_a = '0;
    logic [31:0] drpdo_a = '0;
    logic        drprdy_b = 1'b0;
    logic [15:0] drpdo_b = '0;

    logic [1:0]  drpen_a, drpwe_a;
    logic [9:0]  drpaddr_a;
    logic [15:0] drpdi_a;
    logic        busy_a, done_a;
    logic [1:0]  err_a;
    logic        ech_a;
    logic [1:0]  eidx_a;

    logic        drpen_b, drpwe_b;
    logic [9:0]  drpaddr_b;
    logic [15:0] drpdi_b;
    logic        busy_b, done_b;
    logic [1:0]  err_b;
    logic        ech_b;
    logic [1:0]  eidx_b;

    int n_pass = 0;
    int n_tot = 0;

    exp_t        sq [2][$];
    logic [15:0] mem [3][1024];
    logic [2:0]  mute = '0;
    logic        spur = 1'b0;
    logic        corrupt = 1'b0;
    logic [9:0]  corrupt_addr = '0;
    int          wcount [3];
    int          cnt [3];
    logic [15:0] pend [3];
    logic [2:0]  prdy;
    logic [15:0] pdo [3];
    logic [2:0]  pen, pwe;
    logic [9:0]  adr [3];
    vec_t        vt [8];

    always #5 clk = ~clk;

    gtfwizard_0_example_gtwiz_drp_rmw_seq #(
        .NUM_REG(3), .NUM_CH(2), .ADDR_W(10), .DATA_W(16),
        .TIMEOUT_CYC(15), .VERIFY_EN(1'b0)
    ) dut_a (
        .freerun_clk_in  (clk),
        .freerun_rstn_in (rst_n),
        .start_in        (start_a),
        .alt_mode_in     (alt_a),
        .cfg_addr_in     (cfg_addr),
        .cfg_keep_in     (cfg_keep),
        .cfg_data_in     (cfg_data),
        .cfg_alt_data_in (cfg_alt),
        .cfg_alt_en_in   (cfg_alt_en),
        .drprdy_in       (drprdy_a),
        .drpdo_in        (drpdo_a),
        .drpen_out       (drpen_a),
        .drpwe_out       (drpwe_a),
        .drpaddr_out     (drpaddr_a),
        .drpdi_out       (drpdi_a),
        .busy_out        (busy_a),
        .done_out        (done_a),
        .err_code_out    (err_a),
        .err_ch_out      (ech_a),
        .err_idx_out     (eidx_a)
    );

    gtfwizard_0_example_gtwiz_drp_rmw_seq #(
        .NUM_REG(3), .NUM_CH(1), .ADDR_W(10), .DATA_W(16),
        .TIMEOUT_CYC(1023), .VERIFY_EN(1'b1)
    ) dut_b (
        .freerun_clk_in  (clk),
        .freerun_rstn_in (rst_n),
        .start_in        (start_b),
        .alt_mode_in     (alt_b),
        .cfg_addr_in     (cfg_addr),
        .cfg_keep_in     (cfg_keep),
        .cfg_data_in     (cfg_data),
        .cfg_alt_data_in (cfg_alt),
        .cfg_alt_en_in   (cfg_alt_en),
        .drprdy_in       (drprdy_b),
        .drpdo_in        (drpdo_b),
        .drpen_out       (drpen_b),
        .drpwe_out       (drpwe_b),
        .drpaddr_out     (drpaddr_b),
        .drpdi_out       (drpdi_b),
        .busy_out        (busy_b),
        .done_out        (done_b),
        .err_code_out    (err_b),
        .err_ch_out      (ech_b),
        .err_idx_out     (eidx_b)
    );

    assign pen = {drpen_b, drpen_a};
    assign pwe = {drpwe_b, drpwe_a};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic sb_write(input int p, input int d,
                            input logic [9:0] ad, input logic [15:0] di);
        exp_t e;
        n_tot++;
        if (sq[d].size() == 0) begin
            $display("FAIL write p%0d: unexpected %h=%h", p, ad, di);
        end else begin
            e = sq[d].pop_front();
            if (e.p == p && e.addr == ad && e.data == di) n_pass++;
            else $display("FAIL write: got p%0d %h=%h want p%0d %h=%h",
                          p, ad, di, e.p, e.addr, e.data);
        end
    endtask

    // DRP model: reads return memory after LAT cycles, writes update it.
    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            logic [9:0]  ad;
            logic [15:0] di;
            int          d;
            d  = (p == 2) ? 1 : 0;
            ad = d ? drpaddr_b : drpaddr_a;
            di = d ? drpdi_b : drpdi_a;
            prdy[p] = 1'b0;
            pdo[p]  = 16'h5A5A;
            if (!rst_n) begin
                cnt[p] = 0;
            end else begin
                if (cnt[p] > 0) begin
                    cnt[p]--;
                    if (cnt[p] == 0) begin
                        prdy[p] = 1'b1;
                        pdo[p]  = pend[p];
                    end
                end
                if (pen[p] && !mute[p]) begin
                    cnt[p] = LAT;
                    if (pwe[p]) begin
                        sb_write(p, d, ad, di);
                        mem[p][ad] = di ^ ((d == 1 && corrupt && ad == corrupt_addr)
                                           ? 16'h0100 : 16'h0000);
                        wcount[p]++;
                    end else begin
                        pend[p] = mem[p][ad];
                    end
                end
            end
        end
        drprdy_a = {prdy[1] | spur, prdy[0]};
        drpdo_a  = {prdy[1] ? pdo[1] : (spur ? 16'h0000 : 16'h5A5A), pdo[0]};
        drprdy_b = prdy[2];
        drpdo_b  = pdo[2];
    end

    task automatic init_mem(input logic [15:0] v);
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 1024; a++) mem[p][a] = v;
        for (int p = 0; p < 3; p++) wcount[p] = 0;
    endtask

    task automatic push_exp(input int d, input int nch, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] w [3];
        w = '{w0, w1, w2};
        for (int c = 0; c < nch; c++)
            for (int i = 0; i < 3; i++)
                sq[d].push_back('{p: (d == 1) ? 2 : c, addr: adr[i], data: w[i]});
    endtask

    task automatic wait_done(input int d, input int lim);
        int k;
        k = 0;
        while (!((d == 0) ? done_a : done_b) && k < lim) begin
            @(negedge clk);
            k++;
        end
        n_tot++;
        if (k < lim) n_pass++;
        else $display("FAIL wait_done dut%0d: no done after %0d cycles", d, lim);
    endtask

    task automatic run_vec(input vec_t v);
        init_mem(v.init);
        mute       = {1'b0, v.mute1, 1'b0};
        alt_a      = v.alt_mode;
        alt_b      = v.alt_mode;
        cfg_alt_en = v.alt_en;
        cfg_alt    = {3{v.alt_d}};
        push_exp(0, v.mute1 ? 1 : 2, v.wd0, v.wd1, v.wd2);
        push_exp(1, 1, v.wd0, v.wd1, v.wd2);
        start_a = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        chk({v.nm, "_start"}, {busy_a, done_a, err_a, busy_b, done_b, err_b},
            8'b1000_1000);
        start_a = 1'b0;
        start_b = 1'b0;
        wait_done(0, 600);
        wait_done(1, 600);
        chk({v.nm, "_res_a"}, {done_a, busy_a, err_a, ech_a, eidx_a},
            {1'b1, 1'b0, v.err, v.ech, v.eidx});
        chk({v.nm, "_res_b"}, {done_b, busy_b, err_b}, 4'b1000);
        chk({v.nm, "_queue"}, sq[0].size() + sq[1].size(), 0);
    endtask

    initial begin
        int k;
        cfg_addr   = {10'h08A, 10'h061, 10'h03A};
        cfg_keep   = {16'hBEFF, 16'h07FF, 16'h00FF};
        cfg_data   = {16'h4100, 16'h8000, 16'h8300};
        cfg_alt    = '0;
        cfg_alt_en = '0;
        adr = '{10'h03A, 10'h061, 10'h08A};
        init_mem(16'hFFFF);

        vt[0] = '{"base", 0, 3'b000, 16'h0000, 16'hFFFF, 0,
                  16'h83FF, 16'h87FF, 16'hFFFF, 2'd0, 1'b0, 2'd0};
        vt[1] = '{"alt_e2", 1, 3'b100, 16'h0000, 16'hFFFF, 0,
                  16'h83FF, 16'h87FF, 16'hBEFF, 2'd0, 1'b0, 2'd0};
        vt[2] = '{"alt_off", 0, 3'b100, 16'h0000, 16'hFFFF, 0,
                  16'h83FF, 16'h87FF, 16'hFFFF, 2'd0, 1'b0, 2'd0};
        vt[3] = '{"alt_noen", 1, 3'b000, 16'h0000, 16'hFFFF, 0,
                  16'h83FF, 16'h87FF, 16'hFFFF, 2'd0, 1'b0, 2'd0};
        vt[4] = '{"alt_e0", 1, 3'b001, 16'h1234, 16'hFFFF, 0,
                  16'h12FF, 16'h87FF, 16'hFFFF, 2'd0, 1'b0, 2'd0};
        vt[5] = '{"rd_zero", 0, 3'b000, 16'h0000, 16'h0000, 0,
                  16'h8300, 16'h8000, 16'h4100, 2'd0, 1'b0, 2'd0};
        vt[6] = '{"rd_mix", 0, 3'b000, 16'h0000, 16'hA5A5, 0,
                  16'h83A5, 16'h85A5, 16'hE5A5, 2'd0, 1'b0, 2'd0};
        vt[7] = '{"timeout", 0, 3'b000, 16'h0000, 16'hFFFF, 1,
                  16'h83FF, 16'h87FF, 16'hFFFF, 2'd1, 1'b1, 2'd0};

        repeat (3) @(negedge clk);
        chk("rst_a", {drpen_a, drpwe_a, drpaddr_a, drpdi_a, busy_a, done_a,
                      err_a, ech_a, eidx_a}, 0);
        chk("rst_b", {drpen_b, drpwe_b, drpaddr_b, drpdi_b, busy_b, done_b,
                      err_b, ech_b, eidx_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {busy_a, busy_b}, 0);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Verify mismatch on entry 1 is reported but the walk completes.
        init_mem(16'hFFFF);
        mute = '0;
        alt_b = 1'b0;
        cfg_alt_en = '0;
        corrupt = 1'b1;
        corrupt_addr = 10'h061;
        push_exp(1, 1, 16'h83FF, 16'h87FF, 16'hFFFF);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1, 600);
        chk("vf_err", {done_b, busy_b, err_b, ech_b, eidx_b},
            {1'b1, 1'b0, 2'd2, 1'b0, 2'd1});
        chk("vf_queue", sq[1].size(), 0);
        corrupt = 1'b0;

        // Ready on channel 1 while channel 0 is active must be ignored.
        init_mem(16'hFFFF);
        alt_a = 1'b0;
        push_exp(0, 2, 16'h83FF, 16'h87FF, 16'hFFFF);
        spur = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (wcount[0] < 3 && k < 300) begin
            @(negedge clk);
            k++;
        end
        spur = 1'b0;
        wait_done(0, 600);
        chk("spur_res", {done_a, err_a}, 3'b100);
        chk("spur_queue", sq[0].size(), 0);

        // A second start edge while busy must not retrigger.
        init_mem(16'hFFFF);
        push_exp(0, 2, 16'h83FF, 16'h87FF, 16'hFFFF);
        start_a = 1'b1;
        repeat (4) @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("dbl_busy", busy_a, 1);
        wait_done(0, 600);
        repeat (60) @(negedge clk);
        chk("dbl_idle", {busy_a, done_a}, 2'b01);
        chk("dbl_writes", wcount[0] + wcount[1], 6);
        chk("dbl_queue", sq[0].size(), 0);

        // Reset in WR_WAIT, then start held high across release.
        init_mem(16'hFFFF);
        push_exp(0, 2, 16'h83FF, 16'h87FF, 16'hFFFF);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (wcount[0] < 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        start_a = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a", {drpen_a, drpwe_a, drpaddr_a, drpdi_a, busy_a,
                          done_a, err_a, ech_a, eidx_a}, 0);
        chk("rst_mid_b", {busy_b, done_b, err_b, eidx_b}, 0);
        sq[0].delete();
        sq[1].delete();
        init_mem(16'hFFFF);
        push_exp(0, 2, 16'h83FF, 16'h87FF, 16'hFFFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_start", busy_a, 1);
        wait_done(0, 600);
        repeat (30) @(negedge clk);
        chk("rel_once", {busy_a, done_a, err_a}, 4'b0100);
        chk("rel_writes", wcount[0] + wcount[1], 6);
        chk("rel_queue", sq[0].size(), 0);
        start_a = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
